// File: rtl/cacheline_arbiter_n_if.sv
// Client-side request/response bus of cacheline_arbiter_n; the arbiter takes the slave modport.
interface cacheline_arbiter_n_if #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned LINE   = 256
);
   logic [NUM_CH-1:0]      req_read_i;
   logic [NUM_CH-1:0]      req_write_i;
   logic [NUM_CH*32-1:0]   req_address_i;
   logic [NUM_CH*LINE-1:0] req_wdata_i;
   logic [NUM_CH-1:0]      req_resp_o;
   logic [LINE-1:0]        req_rdata_o;

   modport master (
      output req_read_i, req_write_i, req_address_i, req_wdata_i,
      input  req_resp_o, req_rdata_o
   );

   modport slave (
      input  req_read_i, req_write_i, req_address_i, req_wdata_i,
      output req_resp_o, req_rdata_o
   );
endinterface

// File: rtl/cacheline_arbiter_n.sv
// N-client cacheline arbiter in front of a single cacheline adaptor, one transaction in flight.
// Optional per-client grant/stall counters are built when ARB_PERF_CNT_EN is defined.
module cacheline_arbiter_n #(
   parameter int unsigned NUM_CH   = 2,
   parameter int unsigned s_offset = 5,
   parameter int unsigned RR_MODE  = 1,
   localparam int unsigned LINE    = (2 ** s_offset) * 8
) (
   input  logic                    clk,
   input  logic                    rst,
   cacheline_arbiter_n_if.slave    req_if,
`ifdef ARB_PERF_CNT_EN
   output logic [NUM_CH*32-1:0]    perf_grant_o,
   output logic [NUM_CH*32-1:0]    perf_stall_o,
`endif
   output logic [31:0]             pmem_address_c,
   output logic                    pmem_read_c,
   output logic                    pmem_write_c,
   output logic [LINE-1:0]         pmem_wdata_c,
   input  logic [LINE-1:0]         pmem_rdata_c,
   input  logic                    pmem_resp_c
);

   localparam int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned IDX_W1 = IDX_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      TURN = 2'd2
   } state_e;

   typedef struct packed {
      logic [31:0]     addr;
      logic [LINE-1:0] wdata;
      logic            rd;
      logic            wr;
   } xact_t;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
   xact_t             xact_q, xact_d;

   logic [NUM_CH-1:0] req_c;
   logic              win_vld_c;
   logic [IDX_W-1:0]  win_idx_c;
   logic [IDX_W1-1:0] cand_c;
   logic              done_c;
   logic [NUM_CH-1:0] resp_c;

   assign req_c = req_if.req_read_i | req_if.req_write_i;

   // Winner search: rotating start at rr_ptr in round-robin mode, index 0 upward otherwise.
   always_comb begin
      win_vld_c = 1'b0;
      win_idx_c = '0;
      cand_c    = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (RR_MODE != 0) begin
            cand_c = IDX_W1'(rr_ptr_q) + IDX_W1'(i);
            if (cand_c >= IDX_W1'(NUM_CH)) begin
               cand_c = cand_c - IDX_W1'(NUM_CH);
            end
         end else begin
            cand_c = IDX_W1'(i);
         end
         if (!win_vld_c && req_c[cand_c[IDX_W-1:0]]) begin
            win_vld_c = 1'b1;
            win_idx_c = cand_c[IDX_W-1:0];
         end
      end
   end

   // Next-state and datapath latch.
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      gnt_idx_d = gnt_idx_q;
      xact_d    = xact_q;
      done_c    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (win_vld_c) begin
               gnt_idx_d    = win_idx_c;
               rr_ptr_d     = (win_idx_c == IDX_W'(NUM_CH - 1)) ? '0 : win_idx_c + IDX_W'(1);
               xact_d.addr  = req_if.req_address_i[32'(win_idx_c) * 32 +: 32];
               xact_d.wdata = req_if.req_wdata_i[32'(win_idx_c) * LINE +: LINE];
               // A client raising both strobes is served as a write.
               xact_d.wr    = req_if.req_write_i[win_idx_c];
               xact_d.rd    = req_if.req_read_i[win_idx_c] & ~req_if.req_write_i[win_idx_c];
               state_d      = BUSY;
            end
         end
         BUSY: begin
            if (pmem_resp_c) begin
               done_c    = 1'b1;
               xact_d.rd = 1'b0;
               xact_d.wr = 1'b0;
               state_d   = TURN;
            end
         end
         TURN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         gnt_idx_q <= '0;
         xact_q    <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         gnt_idx_q <= gnt_idx_d;
         xact_q    <= xact_d;
      end
   end

   // Completion pulse goes straight through to the granted client.
   always_comb begin
      resp_c = '0;
      if (done_c) begin
         resp_c[gnt_idx_q] = 1'b1;
      end
   end

   assign req_if.req_resp_o  = resp_c;
   assign req_if.req_rdata_o = done_c ? pmem_rdata_c : '0;

   assign pmem_address_c = xact_q.addr;
   assign pmem_read_c    = xact_q.rd;
   assign pmem_write_c   = xact_q.wr;
   assign pmem_wdata_c   = xact_q.wdata;

`ifdef ARB_PERF_CNT_EN
   logic [NUM_CH-1:0][31:0] grant_cnt_q;
   logic [NUM_CH-1:0][31:0] stall_cnt_q;
   logic [NUM_CH-1:0]       grant_c;
   logic [NUM_CH-1:0]       served_c;

   // A client counts as served while it is being granted or owns the in-flight transaction.
   always_comb begin
      grant_c  = '0;
      served_c = '0;
      if (state_q == IDLE) begin
         if (win_vld_c) begin
            grant_c[win_idx_c]  = 1'b1;
            served_c[win_idx_c] = 1'b1;
         end
      end else begin
         served_c[gnt_idx_q] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (grant_c[c] && (grant_cnt_q[c] != 32'hFFFF_FFFF)) begin
               grant_cnt_q[c] <= grant_cnt_q[c] + 32'd1;
            end
            if (req_c[c] && !served_c[c] && (stall_cnt_q[c] != 32'hFFFF_FFFF)) begin
               stall_cnt_q[c] <= stall_cnt_q[c] + 32'd1;
            end
         end
      end
   end

   assign perf_grant_o = grant_cnt_q;
   assign perf_stall_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cacheline_arbiter_n.sv
// Directed bench for cacheline_arbiter_n: three instances (2-ch RR, 4-ch fixed, 3-ch RR).
module tb_cacheline_arbiter_n;

   localparam int unsigned LINE = 256;

   logic clk;
   logic rst;

   cacheline_arbiter_n_if #(.NUM_CH(2), .LINE(LINE)) if_a ();
   cacheline_arbiter_n_if #(.NUM_CH(4), .LINE(LINE)) if_b ();
   cacheline_arbiter_n_if #(.NUM_CH(3), .LINE(LINE)) if_c ();

   logic [31:0]     pa_addr, pb_addr, pc_addr;
   logic            pa_rd, pb_rd, pc_rd;
   logic            pa_wr, pb_wr, pc_wr;
   logic [LINE-1:0] pa_wdata, pb_wdata, pc_wdata;
   logic [LINE-1:0] pa_rdata, pb_rdata, pc_rdata;
   logic            pa_resp, pb_resp, pc_resp;

`ifdef ARB_PERF_CNT_EN
   logic [2*32-1:0] perf_grant_a, perf_stall_a;
   logic [4*32-1:0] perf_grant_b, perf_stall_b;
   logic [3*32-1:0] perf_grant_c, perf_stall_c;
`endif

   cacheline_arbiter_n #(.NUM_CH(2), .s_offset(5), .RR_MODE(1)) dut_a (
      .clk(clk), .rst(rst), .req_if(if_a),
`ifdef ARB_PERF_CNT_EN
      .perf_grant_o(perf_grant_a), .perf_stall_o(perf_stall_a),
`endif
      .pmem_address_c(pa_addr), .pmem_read_c(pa_rd), .pmem_write_c(pa_wr),
      .pmem_wdata_c(pa_wdata), .pmem_rdata_c(pa_rdata), .pmem_resp_c(pa_resp)
   );

   cacheline_arbiter_n #(.NUM_CH(4), .s_offset(5), .RR_MODE(0)) dut_b (
      .clk(clk), .rst(rst), .req_if(if_b),
`ifdef ARB_PERF_CNT_EN
      .perf_grant_o(perf_grant_b), .perf_stall_o(perf_stall_b),
`endif
      .pmem_address_c(pb_addr), .pmem_read_c(pb_rd), .pmem_write_c(pb_wr),
      .pmem_wdata_c(pb_wdata), .pmem_rdata_c(pb_rdata), .pmem_resp_c(pb_resp)
   );

   cacheline_arbiter_n #(.NUM_CH(3), .s_offset(5), .RR_MODE(1)) dut_c (
      .clk(clk), .rst(rst), .req_if(if_c),
`ifdef ARB_PERF_CNT_EN
      .perf_grant_o(perf_grant_c), .perf_stall_o(perf_stall_c),
`endif
      .pmem_address_c(pc_addr), .pmem_read_c(pc_rd), .pmem_write_c(pc_wr),
      .pmem_wdata_c(pc_wdata), .pmem_rdata_c(pc_rdata), .pmem_resp_c(pc_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Adaptor stand-in: one shared response driver routed to the instance under test.
   int unsigned     sel;
   logic            pm_resp;
   logic [LINE-1:0] pm_rdata;

   assign pa_resp  = pm_resp & (sel == 0);
   assign pb_resp  = pm_resp & (sel == 1);
   assign pc_resp  = pm_resp & (sel == 2);
   assign pa_rdata = pm_rdata;
   assign pb_rdata = pm_rdata;
   assign pc_rdata = pm_rdata;

   logic            obs_rd, obs_wr;
   logic [31:0]     obs_addr;
   logic [LINE-1:0] obs_wdata, obs_rdata;
   logic [7:0]      obs_resp;

   always_comb begin
      obs_rd    = pa_rd;
      obs_wr    = pa_wr;
      obs_addr  = pa_addr;
      obs_wdata = pa_wdata;
      obs_rdata = if_a.req_rdata_o;
      obs_resp  = 8'(if_a.req_resp_o);
      if (sel == 1) begin
         obs_rd    = pb_rd;
         obs_wr    = pb_wr;
         obs_addr  = pb_addr;
         obs_wdata = pb_wdata;
         obs_rdata = if_b.req_rdata_o;
         obs_resp  = 8'(if_b.req_resp_o);
      end else if (sel == 2) begin
         obs_rd    = pc_rd;
         obs_wr    = pc_wr;
         obs_addr  = pc_addr;
         obs_wdata = pc_wdata;
         obs_rdata = if_c.req_rdata_o;
         obs_resp  = 8'(if_c.req_resp_o);
      end
   end

   int unsigned n_tests;
   int unsigned n_fail;

   task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h want=%0h", tag, act, exp);
      end
   endtask

   task automatic clr_req();
      if_a.req_read_i = '0; if_a.req_write_i = '0; if_a.req_address_i = '0; if_a.req_wdata_i = '0;
      if_b.req_read_i = '0; if_b.req_write_i = '0; if_b.req_address_i = '0; if_b.req_wdata_i = '0;
      if_c.req_read_i = '0; if_c.req_write_i = '0; if_c.req_address_i = '0; if_c.req_wdata_i = '0;
   endtask

   task automatic do_reset();
      clr_req();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Called at an IDLE negedge with requests applied; returns at the TURN negedge.
   task automatic run_xact(input string tag, input int unsigned lat, input logic [7:0] exp_gnt,
                           input logic [31:0] exp_addr, input logic exp_wr,
                           input logic [255:0] exp_wdata, input logic [255:0] rline);
      @(negedge clk);
      chk({tag, "_rd"}, 256'(obs_rd), 256'(!exp_wr));
      chk({tag, "_wr"}, 256'(obs_wr), 256'(exp_wr));
      chk({tag, "_addr"}, 256'(obs_addr), 256'(exp_addr));
      if (exp_wr) chk({tag, "_wdata"}, obs_wdata, exp_wdata);
      repeat (lat - 1) begin
         @(negedge clk);
         chk({tag, "_hold"}, 256'(obs_addr), 256'(exp_addr));
      end
      pm_rdata = rline;
      pm_resp  = 1'b1;
      #1;
      chk({tag, "_resp"}, 256'(obs_resp), 256'(exp_gnt));
      if (!exp_wr) chk({tag, "_rdata"}, obs_rdata, rline);
      @(negedge clk);
      chk({tag, "_turn_resp"}, 256'(obs_resp), 256'(0));
      chk({tag, "_turn_strb"}, 256'({obs_rd, obs_wr}), 256'(0));
      pm_resp = 1'b0;
   endtask

   task automatic gap();
      @(negedge clk);
      chk("gap_strb", 256'({obs_rd, obs_wr}), 256'(0));
   endtask

   logic [255:0] line_a5, line_dead, line_rw;

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      sel       = 0;
      pm_resp   = 1'b0;
      pm_rdata  = '0;
      line_a5   = {32{8'hA5}};
      line_dead = {16{16'hDEAD}};
      line_rw   = {8{32'h1234_5678}};
      clr_req();
      rst = 1'b1;
      repeat (2) @(negedge clk);

      chk("rst_rd", 256'(pa_rd), 256'(0));
      chk("rst_wr", 256'(pa_wr), 256'(0));
      chk("rst_addr", 256'(pa_addr), 256'(0));
      chk("rst_resp", 256'(if_a.req_resp_o), 256'(0));
      chk("rst_rdata", if_a.req_rdata_o, 256'(0));
      rst = 1'b0;

      // T1: single read, response after 5 cycles
      sel = 0;
      if_a.req_read_i          = 2'b01;
      if_a.req_address_i[31:0] = 32'h100;
      run_xact("t1", 5, 8'b01, 32'h100, 1'b0, '0, line_a5);
      if_a.req_read_i = '0;
      gap();
`ifdef ARB_PERF_CNT_EN
      chk("t1_perf_grant0", 256'(perf_grant_a[31:0]), 256'(1));
`endif

      // T2: two continuous readers alternate
      do_reset();
      sel = 0;
      if_a.req_read_i           = 2'b11;
      if_a.req_address_i[31:0]  = 32'h1000;
      if_a.req_address_i[63:32] = 32'h2000;
      for (int k = 0; k < 4; k++) begin
         run_xact($sformatf("t2_%0d", k), 2, (k % 2 == 0) ? 8'b01 : 8'b10,
                  (k % 2 == 0) ? 32'h1000 : 32'h2000, 1'b0, '0, {8{28'h0, 4'(k)}});
         gap();
      end
      clr_req();

      // T3: fixed priority, lowest index wins, ch3 starves
      do_reset();
      sel = 1;
      if_b.req_read_i            = 4'b1110;
      if_b.req_address_i[63:32]  = 32'h1100;
      if_b.req_address_i[95:64]  = 32'h1200;
      if_b.req_address_i[127:96] = 32'h1300;
      run_xact("t3_a", 2, 8'b0010, 32'h1100, 1'b0, '0, line_a5);
      gap();
      run_xact("t3_b", 2, 8'b0010, 32'h1100, 1'b0, '0, line_a5);
      if_b.req_read_i = 4'b1100;
      gap();
      run_xact("t3_c", 2, 8'b0100, 32'h1200, 1'b0, '0, line_a5);
      if_b.req_read_i = 4'b1110;
      gap();
      run_xact("t3_d", 2, 8'b0010, 32'h1100, 1'b0, '0, line_a5);
      if_b.req_read_i = 4'b1000;
      gap();
      run_xact("t3_e", 2, 8'b1000, 32'h1300, 1'b0, '0, line_a5);
      clr_req();
      gap();

      // T4: 3-ch round robin, pointer wraps from 2 to 0 then lands on 1
      do_reset();
      sel = 2;
      if_c.req_read_i           = 3'b010;
      if_c.req_address_i[31:0]  = 32'h3000;
      if_c.req_address_i[63:32] = 32'h3100;
      if_c.req_address_i[95:64] = 32'h3200;
      run_xact("t4_a", 2, 8'b010, 32'h3100, 1'b0, '0, line_a5);
      if_c.req_read_i = 3'b001;
      gap();
      run_xact("t4_wrap", 3, 8'b001, 32'h3000, 1'b0, '0, line_a5);
      if_c.req_read_i = 3'b111;
      gap();
      run_xact("t4_ptr1", 2, 8'b010, 32'h3100, 1'b0, '0, line_a5);
      clr_req();
      gap();

      // T5: write with mid-BUSY request change, then read+write collision
      do_reset();
      sel = 0;
      if_a.req_write_i            = 2'b10;
      if_a.req_address_i[63:32]   = 32'h2000;
      if_a.req_wdata_i[511:256]   = line_dead;
      @(negedge clk);
      chk("t5_wr", 256'(pa_wr), 256'(1));
      chk("t5_rd", 256'(pa_rd), 256'(0));
      chk("t5_addr", 256'(pa_addr), 256'(32'h2000));
      chk("t5_wdata", pa_wdata, line_dead);
      if_a.req_address_i[63:32] = 32'h3000;
      if_a.req_wdata_i[511:256] = '1;
      @(negedge clk);
      chk("t5_addr_hold", 256'(pa_addr), 256'(32'h2000));
      chk("t5_wdata_hold", pa_wdata, line_dead);
      pm_resp = 1'b1;
      #1;
      chk("t5_resp", 256'(if_a.req_resp_o), 256'(2'b10));
      @(negedge clk);
      chk("t5_turn_wr", 256'(pa_wr), 256'(0));
      pm_resp = 1'b0;
      clr_req();
      gap();
      if_a.req_read_i          = 2'b01;
      if_a.req_write_i         = 2'b01;
      if_a.req_address_i[31:0] = 32'h440;
      if_a.req_wdata_i[255:0]  = line_rw;
      run_xact("t5_rw", 2, 8'b01, 32'h440, 1'b1, line_rw, line_a5);
      clr_req();
      gap();

      // T6: reset during BUSY, then a stray adaptor response
      do_reset();
      sel = 0;
      if_a.req_read_i          = 2'b01;
      if_a.req_address_i[31:0] = 32'h100;
      @(negedge clk);
      chk("t6_busy_rd", 256'(pa_rd), 256'(1));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_rd", 256'(pa_rd), 256'(0));
      chk("t6_rst_addr", 256'(pa_addr), 256'(0));
`ifdef ARB_PERF_CNT_EN
      chk("t6_perf_grant", 256'(perf_grant_a), 256'(0));
      chk("t6_perf_stall", 256'(perf_stall_a), 256'(0));
`endif
      rst = 1'b0;
      clr_req();
      @(negedge clk);
      pm_resp = 1'b1;
      #1;
      chk("t6_stray_resp", 256'(if_a.req_resp_o), 256'(0));
      @(negedge clk);
      pm_resp = 1'b0;
      chk("t6_stray_rd", 256'({pa_rd, pa_wr}), 256'(0));
      chk("t6_stray_resp2", 256'(if_a.req_resp_o), 256'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
